// File: rtl/sha_auth_pkg.sv
// Shared types and constants for the SHA authentication initiator and its bench model.
// Word i of a 256-bit value is bits [255-32i -: 32] (word 0 is the most significant).
package sha_auth_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_DIG, LOAD_KEY, WAIT, DONE} state_t;

    localparam int SHA_WORDS  = 8;
    localparam int SHA_ADDR_W = 3;
    localparam logic WC_DIGEST = 1'b1;
    localparam logic WC_BLOCK  = 1'b0;

    localparam logic [255:0] DEF_EXP_DIGEST =
        256'he42c30a65a37f031fe920210a999325f84dc75c7ee90d4d2543cef1936d3fb36;
    localparam logic [255:0] DEF_AUTH_KEY =
        256'h4c4e49536c6e69734c4e49536c6e69734c4e49536c6e69734c4e49536c6e6973;

    function automatic logic [31:0] word_of(input logic [255:0] v,
                                            input logic [SHA_ADDR_W-1:0] i);
        logic [255:0] s;
        s = v << {i, 5'b00000};
        return s[255:224];
    endfunction

endpackage

// File: rtl/sha_auth_driver.sv
// Drives the SHA core memory port: loads the expected digest, streams the user key,
// then waits for digest_valid and reports pass/fail with a failed-attempt lockout.
module sha_auth_driver
    import sha_auth_pkg::*;
#(
    parameter logic [255:0] EXP_DIGEST = DEF_EXP_DIGEST,
    parameter int           TIMEOUT    = 64,
    parameter int           MAX_FAIL   = 3,
    parameter int           FAIL_W     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [31:0]           i_key_data,
    input  logic                  i_key_valid,
    output logic                  o_key_ready,
    output logic                  o_sha_cs,
    output logic                  o_sha_we,
    output logic                  o_sha_wc,
    output logic [SHA_ADDR_W-1:0] o_sha_address,
    output logic [31:0]           o_sha_write_data,
    input  logic                  i_sha_digest_valid,
    output logic                  o_busy,
    output logic                  o_auth_done,
    output logic                  o_auth_pass,
    output logic                  o_locked,
    output logic [FAIL_W-1:0]     o_fail_count
);

    localparam int                    TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [FAIL_W-1:0]     FAIL_LIM = FAIL_W'(MAX_FAIL);
    localparam logic [SHA_ADDR_W-1:0] IDX_LAST = SHA_ADDR_W'(SHA_WORDS - 1);

    state_t                r_state, w_state;
    logic [SHA_ADDR_W-1:0] r_idx, w_idx;
    logic [TMR_W-1:0]      r_timer, w_timer;
    logic [FAIL_W-1:0]     r_fail_cnt, w_fail_cnt, w_fail_inc;
    logic                  r_locked, w_locked;
    logic                  r_pass, w_pass;
    logic                  r_done, w_done;
    logic                  r_busy, w_busy;
    logic                  r_key_ready, w_key_ready;
    logic                  r_cs, w_cs;
    logic                  r_wc, w_wc;
    logic [SHA_ADDR_W-1:0] r_addr, w_addr;
    logic [31:0]           r_wdata, w_wdata;
    logic                  w_xfer;

    assign w_xfer     = i_key_valid & r_key_ready;
    assign w_fail_inc = (r_fail_cnt == '1) ? r_fail_cnt : r_fail_cnt + FAIL_W'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_timer     <= '0;
            r_fail_cnt  <= '0;
            r_locked    <= 1'b0;
            r_pass      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b0;
            r_cs        <= 1'b0;
            r_wc        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_timer     <= w_timer;
            r_fail_cnt  <= w_fail_cnt;
            r_locked    <= w_locked;
            r_pass      <= w_pass;
            r_done      <= w_done;
            r_busy      <= w_busy;
            r_key_ready <= w_key_ready;
            r_cs        <= w_cs;
            r_wc        <= w_wc;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
        end
    end

    // Next values of every output register; sha_cs/we pulse only on a write cycle.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_timer     = r_timer;
        w_fail_cnt  = r_fail_cnt;
        w_locked    = r_locked;
        w_pass      = r_pass;
        w_done      = 1'b0;
        w_key_ready = 1'b0;
        w_cs        = 1'b0;
        w_wc        = r_wc;
        w_addr      = r_addr;
        w_wdata     = r_wdata;

        case (r_state)
            IDLE: begin
                if (i_start && !r_locked) begin
                    w_state = LOAD_DIG;
                    w_idx   = '0;
                    w_pass  = 1'b0;
                end
            end
            LOAD_DIG: begin
                w_cs    = 1'b1;
                w_wc    = WC_DIGEST;
                w_addr  = r_idx;
                w_wdata = word_of(EXP_DIGEST, r_idx);
                w_idx   = r_idx + 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_state     = LOAD_KEY;
                    w_idx       = '0;
                    w_key_ready = 1'b1;
                end
            end
            LOAD_KEY: begin
                w_key_ready = 1'b1;
                if (w_xfer) begin
                    w_cs    = 1'b1;
                    w_wc    = WC_BLOCK;
                    w_addr  = r_idx;
                    w_wdata = i_key_data;
                    w_idx   = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state     = WAIT;
                        w_idx       = '0;
                        w_timer     = '0;
                        w_key_ready = 1'b0;
                    end
                end
            end
            WAIT: begin
                // timer==0 is the settle cycle where digest_valid may still be stale
                if (r_timer == '0) begin
                    w_timer = r_timer + 1'b1;
                end else if (i_sha_digest_valid) begin
                    w_state    = DONE;
                    w_done     = 1'b1;
                    w_pass     = 1'b1;
                    w_fail_cnt = '0;
                end else if (r_timer == TMR_LAST) begin
                    w_state    = DONE;
                    w_done     = 1'b1;
                    w_fail_cnt = w_fail_inc;
                    if (w_fail_inc == FAIL_LIM) w_locked = 1'b1;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    assign o_key_ready      = r_key_ready;
    assign o_sha_cs         = r_cs;
    assign o_sha_we         = r_cs;
    assign o_sha_wc         = r_wc;
    assign o_sha_address    = r_addr;
    assign o_sha_write_data = r_wdata;
    assign o_busy           = r_busy;
    assign o_auth_done      = r_done;
    assign o_auth_pass      = r_pass;
    assign o_locked         = r_locked;
    assign o_fail_count     = r_fail_cnt;

endmodule

// File: tb/tb_sha_auth_driver.sv
// Directed bench for sha_auth_driver with a behavioural SHA match model that raises
// digest_valid a programmable number of cycles after the 8th key write.
module tb_sha_auth_driver;

    logic        clk, reset, start, key_valid, key_ready;
    logic [31:0] key_data;
    logic        sha_cs, sha_we, sha_wc, dv;
    logic [2:0]  sha_address;
    logic [31:0] sha_write_data;
    logic        busy, auth_done, auth_pass, locked;
    logic [1:0]  fail_count;

    sha_auth_driver dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_key_data(key_data), .i_key_valid(key_valid), .o_key_ready(key_ready),
        .o_sha_cs(sha_cs), .o_sha_we(sha_we), .o_sha_wc(sha_wc),
        .o_sha_address(sha_address), .o_sha_write_data(sha_write_data),
        .i_sha_digest_valid(dv), .o_busy(busy), .o_auth_done(auth_done),
        .o_auth_pass(auth_pass), .o_locked(locked), .o_fail_count(fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [31:0] DIG [8] = '{32'he42c30a6, 32'h5a37f031, 32'hfe920210, 32'ha999325f,
                             32'h84dc75c7, 32'hee90d4d2, 32'h543cef19, 32'h36d3fb36};
    logic [255:0] KEY_OK  = 256'h4c4e49536c6e69734c4e49536c6e69734c4e49536c6e69734c4e49536c6e6973;
    logic [255:0] KEY_BAD = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;

    typedef struct { logic wc; logic [2:0] a; logic [31:0] d; } wr_t;
    wr_t wr_q[$];

    logic [31:0] mkey [8];
    int  m_delay = 10, m_width = 0;
    bit  m_force = 0;
    bit  armed = 0;
    int  k = 0, n_done = 0, busy_cnt = 0;
    int  t_start = 0, t_last = 0, t_done = 0;
    logic pass_at_done = 0;

    function automatic logic [31:0] kw(input logic [255:0] v, input int i);
        return v[255-32*i -: 32];
    endfunction

    function automatic bit key_ok();
        for (int i = 0; i < 8; i++) if (mkey[i] !== kw(KEY_OK, i)) return 0;
        return 1;
    endfunction

    // SHA model + bus monitor, sampled on the falling edge
    initial begin
        dv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                armed = 0;
                dv    = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (sha_cs) begin
                    chk("we_with_cs", {31'd0, sha_we}, 32'd1);
                    wr_q.push_back('{sha_wc, sha_address, sha_write_data});
                    if (!sha_wc) begin
                        mkey[sha_address] = sha_write_data;
                        if (sha_address == 3'd7) begin
                            armed  = 1;
                            k      = 0;
                            t_last = cyc;
                        end
                    end
                end
                if (auth_done) begin
                    n_done++;
                    t_done       = cyc;
                    pass_at_done = auth_pass;
                    armed        = 0;
                    dv           = 1'b0;
                end
                if (armed) begin
                    dv = (k >= m_delay) && (m_width == 0 || k < m_delay + m_width)
                         && (m_force || key_ok());
                    k++;
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic stream(input logic [255:0] key, input bit tog, input int nw);
        int i = 0;
        int t = 0;
        int g = 0;
        bit x;
        while (i < nw && g < 300) begin
            @(negedge clk);
            key_data  = kw(key, i);
            key_valid = tog ? (t % 3 == 0) : 1'b1;
            t++;
            g++;
            #1 x = key_valid && key_ready;
            @(posedge clk);
            if (x) i++;
        end
        @(negedge clk);
        key_valid = 1'b0;
        chk("stream_words", i, nw);
    endtask

    task automatic wait_done();
        int g = 0;
        while (n_done == 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", {31'd0, n_done > 0}, 32'd1);
        repeat (3) @(negedge clk);
        chk("done_pulse", n_done, 1);
    endtask

    task automatic attempt(input logic [255:0] key, input bit tog, input int delay,
                           input int width, input bit frc, input int nw);
        wr_q.delete();
        n_done  = 0;
        m_delay = delay;
        m_width = width;
        m_force = frc;
        do_start();
        stream(key, tog, nw);
        if (nw == 8) wait_done();
    endtask

    task automatic chk_writes(input logic [255:0] key, input int nkey);
        chk("wr_count", wr_q.size(), 8 + nkey);
        if (wr_q.size() >= 8 + nkey) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("dig_wc%0d", i),   {31'd0, wr_q[i].wc}, 32'd1);
                chk($sformatf("dig_addr%0d", i), {29'd0, wr_q[i].a}, i);
                chk($sformatf("dig_data%0d", i), wr_q[i].d, DIG[i]);
            end
            for (int i = 0; i < nkey; i++) begin
                chk($sformatf("key_wc%0d", i),   {31'd0, wr_q[8+i].wc}, 32'd0);
                chk($sformatf("key_addr%0d", i), {29'd0, wr_q[8+i].a}, i);
                chk($sformatf("key_data%0d", i), wr_q[8+i].d, kw(key, i));
            end
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_cs"},    {31'd0, sha_cs}, 0);
        chk({tag, "_we"},    {31'd0, sha_we}, 0);
        chk({tag, "_wc"},    {31'd0, sha_wc}, 0);
        chk({tag, "_addr"},  {29'd0, sha_address}, 0);
        chk({tag, "_data"},  sha_write_data, 0);
        chk({tag, "_busy"},  {31'd0, busy}, 0);
        chk({tag, "_kr"},    {31'd0, key_ready}, 0);
        chk({tag, "_done"},  {31'd0, auth_done}, 0);
        chk({tag, "_pass"},  {31'd0, auth_pass}, 0);
        chk({tag, "_lock"},  {31'd0, locked}, 0);
        chk({tag, "_fcnt"},  {30'd0, fail_count}, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; key_valid = 1'b0; key_data = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outs("rst");
        reset = 1'b0;

        // correct key, back-to-back, match 10 cycles after last key write
        attempt(KEY_OK, 0, 10, 0, 0, 8);
        chk_writes(KEY_OK, 8);
        chk("ok_pass", {31'd0, pass_at_done}, 1);
        chk("ok_fcnt", {30'd0, fail_count}, 0);
        chk("ok_lat_start", t_done - t_start, 27);
        chk("ok_lat_key", t_done - t_last, 11);
        chk("ok_pass_held", {31'd0, auth_pass}, 1);
        chk("ok_busy_after", {31'd0, busy}, 0);

        // wrong key, never matched -> timeout
        attempt(KEY_BAD, 0, 10, 0, 0, 8);
        chk_writes(KEY_BAD, 8);
        chk("bad_pass", {31'd0, pass_at_done}, 0);
        chk("bad_lat", t_done - t_last, 64);
        chk("bad_fcnt", {30'd0, fail_count}, 1);
        chk("bad_lock", {31'd0, locked}, 0);

        // throttled key source 1,0,0,1,...; pass clears the fail count
        attempt(KEY_OK, 1, 10, 0, 0, 8);
        chk_writes(KEY_OK, 8);
        chk("tog_pass", {31'd0, pass_at_done}, 1);
        chk("tog_fcnt", {30'd0, fail_count}, 0);

        // match arrives on the same cycle the timer expires -> pass
        attempt(KEY_BAD, 0, 63, 0, 1, 8);
        chk("edge_pass", {31'd0, pass_at_done}, 1);
        chk("edge_lat", t_done - t_last, 64);

        // match only during settle cycle -> ignored, fail
        attempt(KEY_BAD, 0, 0, 1, 1, 8);
        chk("settle_pass", {31'd0, pass_at_done}, 0);
        chk("settle_lat", t_done - t_last, 64);
        chk("settle_fcnt", {30'd0, fail_count}, 1);

        attempt(KEY_BAD, 0, 10, 0, 0, 8);
        chk("f2_fcnt", {30'd0, fail_count}, 2);
        chk("f2_lock", {31'd0, locked}, 0);
        attempt(KEY_BAD, 0, 10, 0, 0, 8);
        chk("f3_fcnt", {30'd0, fail_count}, 3);
        chk("f3_lock", {31'd0, locked}, 1);

        // locked: start is dropped
        wr_q.delete();
        busy_cnt = 0;
        do_start();
        repeat (20) @(negedge clk);
        chk("lock_nowr", wr_q.size(), 0);
        chk("lock_busy", busy_cnt, 0);
        chk("lock_held", {31'd0, locked}, 1);

        reset = 1'b1;
        @(negedge clk);
        chk("rst_unlock", {31'd0, locked}, 0);
        chk("rst_fcnt", {30'd0, fail_count}, 0);
        reset = 1'b0;

        // reset mid key load after 4 key writes
        attempt(KEY_OK, 0, 10, 0, 0, 4);
        chk_writes(KEY_OK, 4);
        chk("mid_cs_before", {31'd0, sha_cs}, 1);
        #2 reset = 1'b1;
        #1 chk_idle_outs("mid");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_idle_busy", {31'd0, busy}, 0);

        attempt(KEY_OK, 0, 10, 0, 0, 8);
        chk_writes(KEY_OK, 8);
        chk("post_pass", {31'd0, pass_at_done}, 1);
        chk("post_fcnt", {30'd0, fail_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
